// File: rtl/bram32_arbiter_if.sv
// rtl/bram32_arbiter_if.sv - requester and BRAM pin bundle for bram32_arbiter
interface bram32_arbiter_if #(
    parameter int AW = 9
);
    logic          i_a_req;
    logic [AW-1:0] i_a_addr;
    logic          o_a_gnt;
    logic          o_a_rvalid;
    logic [31:0]   o_a_rdata;
    logic          i_b_req;
    logic [AW-1:0] i_b_addr;
    logic          i_b_we;
    logic [31:0]   i_b_wdata;
    logic [2:0]    i_b_subaddr;
    logic          o_b_gnt;
    logic          o_b_rvalid;
    logic [31:0]   o_b_rdata;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_we;
    logic [31:0]   o_mem_wdata;
    logic [2:0]    o_mem_subaddr;
    logic [31:0]   i_mem_rdata;

    modport slave (
        input  i_a_req, i_a_addr, i_b_req, i_b_addr, i_b_we, i_b_wdata, i_b_subaddr,
        input  i_mem_rdata,
        output o_a_gnt, o_a_rvalid, o_a_rdata, o_b_gnt, o_b_rvalid, o_b_rdata,
        output o_mem_addr, o_mem_we, o_mem_wdata, o_mem_subaddr
    );

    modport master (
        output i_a_req, i_a_addr, i_b_req, i_b_addr, i_b_we, i_b_wdata, i_b_subaddr,
        output i_mem_rdata,
        input  o_a_gnt, o_a_rvalid, o_a_rdata, o_b_gnt, o_b_rvalid, o_b_rdata,
        input  o_mem_addr, o_mem_we, o_mem_wdata, o_mem_subaddr
    );
endinterface

// File: rtl/bram32_arbiter.sv
// rtl/bram32_arbiter.sv - two-port arbiter sharing one single-port bram32
module bram32_arbiter #(
    parameter int DEPTH    = 512,
    parameter int ARB_MODE = 0,
    parameter int MAX_WAIT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    bram32_arbiter_if.slave    bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    port_e                 rr_last_q, rr_last_d;
    logic [3:0]            b_wait_q, b_wait_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic                  b_wr_q, b_wr_d;
    logic                  gnt_a, gnt_b, contend, a_wins;
    logic                  a_rv, b_rv;
    logic [ADDR_WIDTH-1:0] mem_addr;

    always_comb begin
        contend    = bus.i_a_req & bus.i_b_req;
        a_wins     = (ARB_MODE == 0) ? (rr_last_q == PORT_B) : (b_wait_q != WAIT_MAX);
        gnt_a      = i_rst_n & bus.i_a_req & (~bus.i_b_req | a_wins);
        gnt_b      = i_rst_n & bus.i_b_req & (~bus.i_a_req | ~a_wins);

        rr_last_d  = rr_last_q;
        if (contend && i_rst_n) begin
            rr_last_d = gnt_b ? PORT_B : PORT_A;
        end

        // Counts consecutive lost cycles; any B grant or dropped request restarts it.
        b_wait_d   = 4'd0;
        if (bus.i_b_req && !gnt_b) begin
            b_wait_d = (b_wait_q == WAIT_MAX) ? b_wait_q : b_wait_q + 4'd1;
        end

        a_rvalid_d = gnt_a;
        b_rvalid_d = gnt_b;
        b_wr_d     = gnt_b & bus.i_b_we;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_last_q  <= PORT_B;
            b_wait_q   <= 4'd0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            b_wr_q     <= 1'b0;
        end else begin
            rr_last_q  <= rr_last_d;
            b_wait_q   <= b_wait_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            b_wr_q     <= b_wr_d;
        end
    end

    // Responses in flight are suppressed while reset is held so they never surface.
    assign a_rv     = a_rvalid_q & i_rst_n;
    assign b_rv     = b_rvalid_q & i_rst_n;
    assign mem_addr = gnt_b ? bus.i_b_addr : bus.i_a_addr;

    assign bus.o_a_gnt       = gnt_a;
    assign bus.o_b_gnt       = gnt_b;
    assign bus.o_a_rvalid    = a_rv;
    assign bus.o_b_rvalid    = b_rv;
    assign bus.o_a_rdata     = a_rv ? bus.i_mem_rdata : 32'd0;
    assign bus.o_b_rdata     = (b_rv && !b_wr_q) ? bus.i_mem_rdata : 32'd0;
    assign bus.o_mem_addr    = mem_addr;
    assign bus.o_mem_we      = gnt_b & bus.i_b_we;
    assign bus.o_mem_wdata   = gnt_b ? bus.i_b_wdata : 32'd0;
    assign bus.o_mem_subaddr = gnt_b ? bus.i_b_subaddr : 3'd0;
endmodule

// File: tb/tb_bram32_arbiter.sv
// tb/tb_bram32_arbiter.sv - scoreboard bench for bram32_arbiter in both arbitration modes
module tb_bram32_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails = 0;
    logic suppress = 1'b0;

    logic [31:0] expq [4][$];
    logic [31:0] mem0 [512];
    logic [31:0] mem1 [512];

    always #5 clk = ~clk;

    bram32_arbiter_if #(.AW(9)) bus0 ();
    bram32_arbiter_if #(.AW(9)) bus1 ();

    bram32_arbiter #(.DEPTH(512), .ARB_MODE(0), .MAX_WAIT(4)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus0)
    );
    bram32_arbiter #(.DEPTH(512), .ARB_MODE(1), .MAX_WAIT(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [2:0] sub);
        logic [31:0] m;
        case (sub)
            3'd1:    m = 32'hFFFF_FFFF;
            3'd2:    m = 32'h0000_FFFF;
            3'd3:    m = 32'hFFFF_0000;
            3'd4:    m = 32'h0000_00FF;
            3'd5:    m = 32'h0000_FF00;
            3'd6:    m = 32'h00FF_0000;
            3'd7:    m = 32'hFF00_0000;
            default: m = 32'h0;
        endcase
        return (old & ~m) | (wd & m);
    endfunction

    always @(posedge clk) begin
        if (bus0.o_mem_we) mem0[bus0.o_mem_addr] <= merge(mem0[bus0.o_mem_addr], bus0.o_mem_wdata, bus0.o_mem_subaddr);
        if (bus1.o_mem_we) mem1[bus1.o_mem_addr] <= merge(mem1[bus1.o_mem_addr], bus1.o_mem_wdata, bus1.o_mem_subaddr);
        bus0.i_mem_rdata <= mem0[bus0.o_mem_addr];
        bus1.i_mem_rdata <= mem1[bus1.o_mem_addr];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mon(input int k, input logic rv, input logic [31:0] rd, input string nm);
        logic [31:0] e;
        if (rv === 1'b1) begin
            if (expq[k].size() == 0) begin
                checks++;
                fails++;
                $display("FAIL %s: unexpected rvalid, got %h expected no response at %0t", nm, rd, $time);
            end else begin
                e = expq[k].pop_front();
                check(nm, rd, e);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.o_a_rvalid, bus0.o_a_rdata, "a_rdata_m0");
        mon(1, bus0.o_b_rvalid, bus0.o_b_rdata, "b_rdata_m0");
        mon(2, bus1.o_a_rvalid, bus1.o_a_rdata, "a_rdata_m1");
        mon(3, bus1.o_b_rvalid, bus1.o_b_rdata, "b_rdata_m1");
        check("dual_rvalid_m0", {31'd0, bus0.o_a_rvalid & bus0.o_b_rvalid}, 32'd0);
        check("dual_rvalid_m1", {31'd0, bus1.o_a_rvalid & bus1.o_b_rvalid}, 32'd0);
    end

    task automatic drive(input logic rst, input logic ar, input logic [8:0] aa,
                         input logic br, input logic [8:0] ba, input logic bwe,
                         input logic [31:0] bwd, input logic [2:0] bs,
                         input logic ega0, input logic egb0, input logic ega1, input logic egb1,
                         input logic [31:0] ea, input logic [31:0] eb);
        @(posedge clk);
        #1;
        rst_n = rst;
        bus0.i_a_req = ar;  bus1.i_a_req = ar;
        bus0.i_a_addr = aa; bus1.i_a_addr = aa;
        bus0.i_b_req = br;  bus1.i_b_req = br;
        bus0.i_b_addr = ba; bus1.i_b_addr = ba;
        bus0.i_b_we = bwe;  bus1.i_b_we = bwe;
        bus0.i_b_wdata = bwd; bus1.i_b_wdata = bwd;
        bus0.i_b_subaddr = bs; bus1.i_b_subaddr = bs;
        #1;
        check("a_gnt_m0", {31'd0, bus0.o_a_gnt}, {31'd0, ega0});
        check("b_gnt_m0", {31'd0, bus0.o_b_gnt}, {31'd0, egb0});
        check("a_gnt_m1", {31'd0, bus1.o_a_gnt}, {31'd0, ega1});
        check("b_gnt_m1", {31'd0, bus1.o_b_gnt}, {31'd0, egb1});
        check("mem_we_m0", {31'd0, bus0.o_mem_we}, {31'd0, egb0 & bwe});
        check("mem_we_m1", {31'd0, bus1.o_mem_we}, {31'd0, egb1 & bwe});
        check("mem_addr_m0", {23'd0, bus0.o_mem_addr}, {23'd0, egb0 ? ba : aa});
        if (!suppress) begin
            if (ega0) expq[0].push_back(ea);
            if (egb0) expq[1].push_back(eb);
            if (ega1) expq[2].push_back(ea);
            if (egb1) expq[3].push_back(eb);
        end
    endtask

    task automatic idle(input logic rst);
        drive(rst, 1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem0[i] = 32'd0;
            mem1[i] = 32'd0;
        end
        mem0[5] = 32'hDEADBEEF; mem1[5] = 32'hDEADBEEF;
        mem0[3] = 32'h11223344; mem1[3] = 32'h11223344;
        rst_n = 1'b0;
        bus0.i_a_req = 1'b0; bus1.i_a_req = 1'b0;
        bus0.i_a_addr = '0;  bus1.i_a_addr = '0;
        bus0.i_b_req = 1'b0; bus1.i_b_req = 1'b0;
        bus0.i_b_addr = '0;  bus1.i_b_addr = '0;
        bus0.i_b_we = 1'b0;  bus1.i_b_we = 1'b0;
        bus0.i_b_wdata = '0; bus1.i_b_wdata = '0;
        bus0.i_b_subaddr = '0; bus1.i_b_subaddr = '0;

        // reset held with both ports requesting, B asking for a write
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 9'd5, 1'b1, 9'd3, 1'b1, 32'hFFFF_FFFF, 3'd1,
                  1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(1'b1);

        // A alone
        drive(1'b1, 1'b1, 9'd5, 1'b0, 9'd0, 1'b0, 32'd0, 3'd0,
              1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'd0);
        idle(1'b1);

        // B byte-lane write then read-after-write
        drive(1'b1, 1'b0, 9'd0, 1'b1, 9'd3, 1'b1, 32'h00AB0000, 3'd6,
              1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 9'd0, 1'b1, 9'd3, 1'b0, 32'd0, 3'd1,
              1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'h11AB3344);
        // write with subaddr 0 is acked but must not alter word 3
        drive(1'b1, 1'b0, 9'd0, 1'b1, 9'd3, 1'b1, 32'hCAFEF00D, 3'd0,
              1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 9'd0, 1'b1, 9'd3, 1'b0, 32'd0, 3'd1,
              1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'h11AB3344);
        idle(1'b1);

        // continuous contention: m0 alternates, m1 gives B one slot after 4 losses
        for (int i = 0; i < 10; i++)
            drive(1'b1, 1'b1, 9'd5, 1'b1, 9'd3, 1'b0, 32'd0, 3'd1,
                  (i % 2) == 0, (i % 2) == 1, (i % 5) != 4, (i % 5) == 4,
                  32'hDEADBEEF, 32'h11AB3344);
        idle(1'b1);

        // A grant whose response is killed by reset in the next cycle
        suppress = 1'b1;
        drive(1'b1, 1'b1, 9'd5, 1'b0, 9'd0, 1'b0, 32'd0, 3'd0,
              1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        suppress = 1'b0;
        drive(1'b0, 1'b1, 9'd5, 1'b1, 9'd3, 1'b0, 32'd0, 3'd1,
              1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("a_rvalid_rst_m0", {31'd0, bus0.o_a_rvalid}, 32'd0);
        check("a_rvalid_rst_m1", {31'd0, bus1.o_a_rvalid}, 32'd0);
        drive(1'b1, 1'b1, 9'd5, 1'b1, 9'd3, 1'b0, 32'd0, 3'd1,
              1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'd0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        for (int k = 0; k < 4; k++)
            check($sformatf("pending_q%0d", k), expq[k].size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
